regfile_mp: RTL and testbench

Parametrised multi-port integer register file, the successor to the single-write, two-read register file in the RISC-V core.
- N read ports and M write ports.
- Write-to-read bypass with deterministic write-port priority.
- Hardwired zero register.
- Per-register busy scoreboard for hazard detection.
- Post-reset clear sequencer that zeroes the storage array. The array itself is not reset.

It sits between the decode/issue stage (reads, busy marking) and writeback (writes, busy clearing).

---
 rtl/regfile_pkg.sv | 35 +++
 rtl/regfile_scoreboard.sv | 62 ++++++
 rtl/regfile_mp.sv | 121 ++++++++++++
 tb/tb_regfile_mp.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // Upper bound on write ports handled by the priority picker.
  localparam int MAX_WR = 32;
  localparam int PIDX_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic              hit;
    logic [PIDX_W-1:0] idx;
  } wsel_t;

  // Highest-indexed set bit of a per-port match vector wins.
  function automatic wsel_t pick_port(input logic [MAX_WR-1:0] match);
    wsel_t s;
    s.hit = 1'b0;
    s.idx = '0;
    for (int p = 0; p < MAX_WR; p++) begin
      if (match[p]) begin
        s.hit = 1'b1;
        s.idx = PIDX_W'(p);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback or flush.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Writeback clears, a new issue sets (wins over writeback), flush clears everything.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) busy_d[wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (iss_en && (iss_addr != '0)) busy_d[iss_addr] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Busy vector only advances once the file is out of its clear sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else if (en) begin
      busy_q <= busy_d;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          wr_hit;

    assign addr = rd_addr[gi*AW +: AW];

    // A write landing this cycle resolves the hazard for the reader.
    always_comb begin
      wr_hit = 1'b0;
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) wr_hit = 1'b1;
      end
    end

    assign rd_busy[gi] = en && busy_q[addr] && !wr_hit && (addr != '0);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, zero register and post-reset clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                init_done,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush
);

  state_e          state_q;
  logic [AW-1:0]   clr_cnt_q;
  logic            init_done_q;
  logic            run;
  logic [XLEN-1:0] mem_q [NREG];

  logic [NREG-1:0]      reg_we;
  logic [NREG*XLEN-1:0] reg_wd;

  assign run       = (state_q == RUN);
  assign init_done = init_done_q;

  // Clear sequencer: walk every entry once after reset, then stay in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (clr_cnt_q == AW'(NREG - 1)) begin
        state_q     <= RUN;
        init_done_q <= 1'b1;
      end
    end
  end

  // Per-register winner among the write ports; x0 is never stored.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_wsel
    logic [MAX_WR-1:0] match;
    wsel_t             sel;

    // One match bit per write port aimed at this register.
    always_comb begin
      match = '0;
      for (int p = 0; p < NWR; p++) begin
        match[p] = wr_en[p] && (wr_addr[p*AW +: AW] == AW'(gi));
      end
    end

    assign sel                     = pick_port(match);
    assign reg_we[gi]              = run && sel.hit && (gi != 0);
    assign reg_wd[gi*XLEN +: XLEN] = wr_data[sel.idx*XLEN +: XLEN];
  end

  // Storage is not reset; the clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (reg_we[r]) mem_q[r] <= reg_wd[r*XLEN +: XLEN];
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [MAX_WR-1:0] match;
    wsel_t             sel;

    assign addr = rd_addr[gi*AW +: AW];

    // Bypass candidates: enabled write ports targeting the read address.
    always_comb begin
      match = '0;
      for (int p = 0; p < NWR; p++) begin
        match[p] = wr_en[p] && (wr_addr[p*AW +: AW] == addr);
      end
    end

    assign sel = pick_port(match);
    assign rd_data[gi*XLEN +: XLEN] =
        (!run || (addr == '0)) ? '0 :
        sel.hit                ? wr_data[sel.idx*XLEN +: XLEN] :
                                 mem_q[addr];
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (run),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: expectations queued at drive time, checked before the edge.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  localparam int S_RD0   = 0;
  localparam int S_RD1   = 1;
  localparam int S_BUSY0 = 2;
  localparam int S_BUSY1 = 3;
  localparam int S_INIT  = 4;

  logic                clk;
  logic                rst_n;
  logic                init_done;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl_mem [NREG];

  regfile_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RD0:   return rd_data[31:0];
      S_RD1:   return rd_data[63:32];
      S_BUSY0: return {31'b0, rd_busy[0]};
      S_BUSY1: return {31'b0, rd_busy[1]};
      default: return {31'b0, init_done};
    endcase
  endfunction

  task automatic exp_push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic settle_check;
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic next_cycle;
    settle_check();
    @(negedge clk);
  endtask

  task automatic set_idle;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    flush    = 1'b0;
    rd_addr  = '0;
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]           = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_iss(input logic [4:0] a);
    iss_en   = 1'b1;
    iss_addr = a;
  endtask

  // NREG cycles of clear; optionally hammer the write/issue/flush inputs meanwhile.
  task automatic clear_phase(input bit noisy);
    for (int c = 0; c < NREG; c++) begin
      set_idle();
      if (noisy) begin
        set_wr(0, 5'd1, 32'h1111_1111);
        set_wr(1, 5'(31 - c), 32'hCAFE_0000 | c);
        set_iss(5'd2);
        flush = c[0];
        set_rd(0, 5'd1);
        set_rd(1, 5'(31 - c));
        exp_push("clr_rd0", S_RD0, 32'h0);
        exp_push("clr_rd1", S_RD1, 32'h0);
        exp_push("clr_busy1", S_BUSY1, 32'h0);
      end
      exp_push("clr_init_lo", S_INIT, 32'h0);
      next_cycle();
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (wr_en[1] && wr_addr[9:5] == ra) return wr_data[63:32];
    if (wr_en[0] && wr_addr[4:0] == ra) return wr_data[31:0];
    return mdl_mem[ra];
  endfunction

  initial begin
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    exp_push("rst_init", S_INIT, 32'h0);
    exp_push("rst_busy0", S_BUSY0, 32'h0);
    next_cycle();

    // Clear sequence with all write-side inputs active.
    rst_n = 1'b1;
    clear_phase(1'b1);

    // Every register reads zero; x2 issued during clear is not busy.
    for (int a = 1; a < 32; a += 2) begin
      set_idle();
      set_rd(0, 5'(a));
      set_rd(1, 5'(a + 1));
      exp_push("init_hi", S_INIT, 32'h1);
      exp_push("sweep_rd0", S_RD0, 32'h0);
      exp_push("sweep_rd1", S_RD1, 32'h0);
      exp_push("sweep_busy1", S_BUSY1, 32'h0);
      next_cycle();
    end

    // Same-address write on both ports: port 1 wins, bypass and stored.
    set_idle();
    set_wr(0, 5'd5, 32'hAAAA_0000);
    set_wr(1, 5'd5, 32'h5555_FFFF);
    set_rd(0, 5'd5);
    exp_push("prio_bypass", S_RD0, 32'h5555_FFFF);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      set_idle();
      set_rd(0, 5'd5);
      exp_push("prio_stored", S_RD0, 32'h5555_FFFF);
      next_cycle();
    end

    // x0 stays zero and never busy.
    set_idle();
    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 5'd0, 32'hFFFF_FFFF);
    set_iss(5'd0);
    exp_push("x0_bypass", S_RD0, 32'h0);
    exp_push("x0_busy_now", S_BUSY0, 32'h0);
    next_cycle();
    set_idle();
    exp_push("x0_stored", S_RD0, 32'h0);
    exp_push("x0_busy", S_BUSY0, 32'h0);
    next_cycle();

    // Issue / writeback hazard tracking on x7.
    set_idle();
    set_iss(5'd7);
    set_rd(0, 5'd7);
    set_rd(1, 5'd5);
    exp_push("iss_same_cycle", S_BUSY0, 32'h0);
    exp_push("x7_zero", S_RD0, 32'h0);
    exp_push("x5_persist", S_RD1, 32'h5555_FFFF);
    next_cycle();
    set_idle();
    set_rd(0, 5'd7);
    exp_push("iss_busy", S_BUSY0, 32'h1);
    next_cycle();
    set_idle();
    set_wr(0, 5'd7, 32'h0000_1234);
    set_rd(0, 5'd7);
    exp_push("wb_busy_now", S_BUSY0, 32'h0);
    exp_push("wb_bypass", S_RD0, 32'h0000_1234);
    next_cycle();
    set_idle();
    set_rd(0, 5'd7);
    exp_push("wb_busy_after", S_BUSY0, 32'h0);
    exp_push("wb_stored", S_RD0, 32'h0000_1234);
    next_cycle();
    set_idle();
    set_iss(5'd7);
    set_wr(1, 5'd7, 32'h0000_5678);
    set_rd(0, 5'd7);
    exp_push("iss_wb_now", S_BUSY0, 32'h0);
    exp_push("iss_wb_data", S_RD0, 32'h0000_5678);
    next_cycle();
    set_idle();
    set_rd(0, 5'd7);
    exp_push("iss_wins", S_BUSY0, 32'h1);
    next_cycle();

    // Flush overrides a same-cycle issue.
    set_idle();
    set_iss(5'd3);
    next_cycle();
    set_idle();
    set_iss(5'd9);
    set_rd(0, 5'd3);
    exp_push("x3_busy", S_BUSY0, 32'h1);
    next_cycle();
    set_idle();
    set_iss(5'd12);
    set_rd(1, 5'd9);
    exp_push("x9_busy", S_BUSY1, 32'h1);
    next_cycle();
    set_idle();
    flush = 1'b1;
    set_iss(5'd4);
    set_rd(0, 5'd12);
    set_rd(1, 5'd3);
    exp_push("pre_flush_x12", S_BUSY0, 32'h1);
    exp_push("pre_flush_x3", S_BUSY1, 32'h1);
    next_cycle();
    set_idle();
    set_rd(0, 5'd3);
    set_rd(1, 5'd9);
    exp_push("flush_x3", S_BUSY0, 32'h0);
    exp_push("flush_x9", S_BUSY1, 32'h0);
    next_cycle();
    set_idle();
    set_rd(0, 5'd12);
    set_rd(1, 5'd4);
    exp_push("flush_x12", S_BUSY0, 32'h0);
    exp_push("flush_x4", S_BUSY1, 32'h0);
    next_cycle();

    // Mid-run reset wipes busy state and storage.
    set_idle();
    set_wr(0, 5'd10, 32'hDEAD_BEEF);
    set_iss(5'd11);
    next_cycle();
    set_idle();
    set_rd(0, 5'd10);
    set_rd(1, 5'd11);
    exp_push("x10_written", S_RD0, 32'hDEAD_BEEF);
    exp_push("x11_busy", S_BUSY1, 32'h1);
    exp_push("run_init", S_INIT, 32'h1);
    next_cycle();
    set_idle();
    set_rd(0, 5'd10);
    set_rd(1, 5'd11);
    rst_n = 1'b0;
    exp_push("async_init_lo", S_INIT, 32'h0);
    exp_push("async_busy", S_BUSY1, 32'h0);
    exp_push("async_rd", S_RD0, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    clear_phase(1'b0);
    set_idle();
    set_rd(0, 5'd10);
    set_rd(1, 5'd11);
    exp_push("reinit_hi", S_INIT, 32'h1);
    exp_push("x10_cleared", S_RD0, 32'h0);
    exp_push("x11_not_busy", S_BUSY1, 32'h0);
    next_cycle();

    // Randomised writes/reads over a small address window against a reference model.
    for (int r = 0; r < NREG; r++) mdl_mem[r] = 32'h0;
    for (int n = 0; n < 30; n++) begin
      logic [4:0] ra0;
      logic [4:0] ra1;
      set_idle();
      wr_en   = 2'($urandom_range(0, 3));
      wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {$urandom(), $urandom()};
      ra0 = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      set_rd(0, ra0);
      set_rd(1, ra1);
      exp_push("rand_rd0", S_RD0, model_read(ra0));
      exp_push("rand_rd1", S_RD1, model_read(ra1));
      next_cycle();
      if (wr_en[0] && wr_addr[4:0] != 5'd0) mdl_mem[wr_addr[4:0]] = wr_data[31:0];
      if (wr_en[1] && wr_addr[9:5] != 5'd0) mdl_mem[wr_addr[9:5]] = wr_data[63:32];
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
